matmul_seq: RTL and testbench

Parametrised sequential matrix-multiply accelerator: C = A x B (or C += A x B) for square N x N matrices of DATA_W-bit elements.
- Operands are loaded element-by-element through a write port into internal A/B storage.
- One multiply-accumulate per cycle under an FSM; results are read back through a registered read port.
- Sits behind the peripheral bus as a start/busy/done accelerator.

---
 rtl/matmul_pkg.sv | 52 +++++
 rtl/matmul_mac.sv | 32 +++
 rtl/matmul_seq.sv | 122 ++++++++++++
 tb/tb_matmul_seq.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared types and helpers for the sequential matrix-multiply accelerator.
// sat_add works on a 64-bit carrier; only the low acc_w bits are meaningful.
package matmul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int MAX_W = 64;

    // Add two acc_w-bit values held in the low bits of a and b (acc_w <= 63).
    function automatic logic [MAX_W-1:0] sat_add(
        input logic [MAX_W-1:0] a,
        input logic [MAX_W-1:0] b,
        input logic             signed_mode,
        input logic             sat_en,
        input int               acc_w
    );
        logic [MAX_W:0]        one, mask, ua, ub, us;
        logic signed [MAX_W:0] sa, sb, ss, smax, smin;
        int                    sh;
        one  = (MAX_W+1)'(1);
        mask = (one << acc_w) - one;
        sh   = MAX_W + 1 - acc_w;
        ua   = {1'b0, a} & mask;
        ub   = {1'b0, b} & mask;
        sa   = $signed(ua << sh) >>> sh;
        sb   = $signed(ub << sh) >>> sh;
        us   = ua + ub;
        ss   = sa + sb;
        smax = $signed((one << (acc_w - 1)) - one);
        smin = -$signed(one << (acc_w - 1));
        if (signed_mode) begin
            if (sat_en && (ss > smax))
                ss = smax;
            else if (sat_en && (ss < smin))
                ss = smin;
            us = $unsigned(ss);
        end else if (sat_en && (us > mask)) begin
            us = mask;
        end
        us = us & mask;
        return us[MAX_W-1:0];
    endfunction

    function automatic int idx(input int row, input int col, input int n);
        return row * n + col;
    endfunction

endpackage

// File: rtl/matmul_mac.sv
// One multiply-accumulate step: full-width product, extension to ACC_W,
// then a wrapping or saturating add onto the supplied base.
module matmul_mac
    import matmul_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20,
    parameter int SAT    = 1
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [ACC_W-1:0]  base,
    input  logic              signed_mode,
    output logic [ACC_W-1:0]  acc_next
);
    localparam int PW = 2 * DATA_W;

    logic signed [PW-1:0] prod_s;
    logic [PW-1:0]        prod_u, prod;
    logic [MAX_W-1:0]     prod_x, base_x, sum_x;

    assign prod_s = $signed({{DATA_W{a[DATA_W-1]}}, a}) * $signed({{DATA_W{b[DATA_W-1]}}, b});
    assign prod_u = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
    assign prod   = signed_mode ? $unsigned(prod_s) : prod_u;

    assign prod_x = {{(MAX_W-PW){signed_mode & prod[PW-1]}}, prod};
    assign base_x = {{(MAX_W-ACC_W){1'b0}}, base};
    assign sum_x  = sat_add(base_x, prod_x, signed_mode, SAT != 0, ACC_W);

    assign acc_next = sum_x[ACC_W-1:0];

endmodule

// File: rtl/matmul_seq.sv
// Sequential N x N matrix multiply (C = A*B or C += A*B), one MAC per cycle,
// operands loaded through a write port and results read through a registered port.
module matmul_seq
    import matmul_pkg::*;
#(
    parameter int N      = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20,
    parameter int SAT    = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    cfg_signed,
    input  logic                    cfg_accum,
    output logic                    busy,
    output logic                    done,
    input  logic                    wr_en,
    input  logic                    wr_sel,
    input  logic [$clog2(N*N)-1:0]  wr_addr,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic [$clog2(N*N)-1:0]  rd_addr,
    output logic [ACC_W-1:0]        rd_data
);
    localparam int             NN   = N * N;
    localparam int             AW   = $clog2(NN);
    localparam int             IW   = $clog2(N);
    localparam logic [AW:0]    NN_L = (AW+1)'(NN);
    localparam logic [IW-1:0]  LAST = IW'(N - 1);

    state_e              state;
    logic                sgn_q, accum_q;
    logic [IW-1:0]       i_q, j_q, k_q;
    logic [ACC_W-1:0]    acc_q, base, acc_next;
    logic [DATA_W-1:0]   a_mem [NN];
    logic [DATA_W-1:0]   b_mem [NN];
    logic [ACC_W-1:0]    c_mem [NN];
    logic [AW-1:0]       a_idx, b_idx, c_idx;

    assign a_idx = AW'(idx(int'(i_q), int'(k_q), N));
    assign b_idx = AW'(idx(int'(k_q), int'(j_q), N));
    assign c_idx = AW'(idx(int'(i_q), int'(j_q), N));

    // First k step seeds from C (accumulate) or zero; later steps chain the running sum.
    assign base = (k_q == '0) ? (accum_q ? c_mem[c_idx] : '0) : acc_q;

    matmul_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .SAT    (SAT)
    ) u_mac (
        .a           (a_mem[a_idx]),
        .b           (b_mem[b_idx]),
        .base        (base),
        .signed_mode (sgn_q),
        .acc_next    (acc_next)
    );

    assign busy = (state == MAC);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sgn_q   <= 1'b0;
            accum_q <= 1'b0;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            rd_data <= '0;
            for (int e = 0; e < NN; e++) begin
                a_mem[e] <= '0;
                b_mem[e] <= '0;
                c_mem[e] <= '0;
            end
        end else begin
            rd_data <= ({1'b0, rd_addr} < NN_L) ? c_mem[rd_addr] : '0;
            unique case (state)
                IDLE: begin
                    if (wr_en && ({1'b0, wr_addr} < NN_L)) begin
                        if (wr_sel)
                            b_mem[wr_addr] <= wr_data;
                        else
                            a_mem[wr_addr] <= wr_data;
                    end
                    if (start) begin
                        state   <= MAC;
                        sgn_q   <= cfg_signed;
                        accum_q <= cfg_accum;
                        i_q     <= '0;
                        j_q     <= '0;
                        k_q     <= '0;
                    end
                end
                MAC: begin
                    acc_q <= acc_next;
                    if (k_q == LAST) begin
                        c_mem[c_idx] <= acc_next;
                        k_q          <= '0;
                        if (j_q == LAST) begin
                            j_q <= '0;
                            if (i_q == LAST) begin
                                i_q   <= '0;
                                state <= DONE;
                            end else begin
                                i_q <= i_q + IW'(1);
                            end
                        end else begin
                            j_q <= j_q + IW'(1);
                        end
                    end else begin
                        k_q <= k_q + IW'(1);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_seq.sv
// Scoreboard bench for matmul_seq: a saturating and a wrapping instance share
// stimulus; reads and done pulses are checked by a monitor against queued expectations.
module tb_matmul_seq;
    localparam int N = 4, DW = 8, ACC_W = 16, AW = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0, cfg_signed = 1'b0, cfg_accum = 1'b0;
    logic              wr_en = 1'b0, wr_sel = 1'b0;
    logic [AW-1:0]     wr_addr = '0, rd_addr = '0;
    logic [DW-1:0]     wr_data = '0;
    logic              busy, done, busy_w, done_w;
    logic [ACC_W-1:0]  rd_data, rd_data_w;

    always #5 clk = ~clk;

    matmul_seq #(.N(N), .DATA_W(DW), .ACC_W(ACC_W), .SAT(1)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_signed(cfg_signed), .cfg_accum(cfg_accum),
        .busy(busy), .done(done), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data));

    matmul_seq #(.N(N), .DATA_W(DW), .ACC_W(ACC_W), .SAT(0)) dut_w (
        .clk(clk), .rst(rst), .start(start), .cfg_signed(cfg_signed), .cfg_accum(cfg_accum),
        .busy(busy_w), .done(done_w), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data_w));

    typedef struct {
        string name;
        int    es;
        int    ew;
    } rd_t;

    rd_t  rd_q[$];
    int   done_q[$];
    int   cyc = 0;
    int   n_chk = 0, n_pass = 0;
    logic rd_issue = 1'b0, rd_vld = 1'b0;

    int sa[16] = '{-1, 2, 0, 0, 3, -4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    int sb[16] = '{ 5, 6, 0, 0, 7,  8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rd_vld <= rd_issue;

    function automatic void chk(string name, int act, int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endfunction

    function automatic int u16(int v);
        return v & 32'hFFFF;
    endfunction

    // Monitor: compares registered read data and done timing against the queues.
    always @(negedge clk) begin
        rd_t e;
        if (rd_vld && rd_q.size() > 0) begin
            e = rd_q.pop_front();
            chk(e.name, int'(rd_data), e.es);
            chk({e.name, "_wrap"}, int'(rd_data_w), e.ew);
        end
        if (!rst && done) begin
            if (done_q.size() == 0) chk("done_unexpected", int'(done), 0);
            else chk("done_cycle", cyc, done_q.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(bit sel, int addr, int data);
        wr_en = 1'b1; wr_sel = sel; wr_addr = AW'(addr); wr_data = DW'(data);
        step();
        wr_en = 1'b0;
    endtask

    task automatic rd(string name, int addr, int es, int ew);
        rd_t e;
        e.name = $sformatf("%s_c%0d", name, addr);
        e.es   = u16(es);
        e.ew   = u16(ew);
        rd_q.push_back(e);
        rd_addr  = AW'(addr);
        rd_issue = 1'b1;
        step();
        rd_issue = 1'b0;
    endtask

    task automatic fill(int av, int bv);
        for (int e = 0; e < 16; e++) begin
            wr(1'b0, e, av);
            wr(1'b1, e, bv);
        end
    endtask

    // Start a run; optional write in the start cycle and an optional mid-run poke.
    task automatic run(bit acc, bit sgn, bit poke, bit sw, bit sw_sel, int sw_addr, int sw_data);
        cfg_accum = acc; cfg_signed = sgn; start = 1'b1;
        if (sw) begin
            wr_en = 1'b1; wr_sel = sw_sel; wr_addr = AW'(sw_addr); wr_data = DW'(sw_data);
        end
        done_q.push_back(cyc + 65);
        step();
        start = 1'b0; wr_en = 1'b0;
        cfg_accum = ~acc; cfg_signed = ~sgn;
        chk("busy_after_start", int'(busy), 1);
        if (poke) begin
            repeat (9) step();
            start = 1'b1; wr_en = 1'b1; wr_sel = 1'b0; wr_addr = '0; wr_data = 8'd99;
            step();
            start = 1'b0; wr_en = 1'b0;
        end
        for (int t = 0; t < 80 && !done; t++) step();
        step();
    endtask

    task automatic load_ident(bit skip_last_b);
        for (int e = 0; e < 16; e++) begin
            wr(1'b0, e, (e / 4 == e % 4) ? 1 : 0);
            if (!(skip_last_b && e == 15)) wr(1'b1, e, e);
        end
    endtask

    task automatic check_ident(string name, int mult);
        for (int e = 0; e < 16; e++) rd(name, e, mult * e, mult * e);
    endtask

    initial begin
        repeat (2) step();
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_rd", int'(rd_data), 0);
        chk("rst_busy_wrap", int'(busy_w), 0);
        rst = 1'b0;
        step();

        load_ident(1'b0);
        run(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        check_ident("ident", 1);
        run(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        check_ident("accum", 2);
        run(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        check_ident("restore", 1);

        run(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
        check_ident("busyprot", 1);
        run(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        check_ident("after_busy", 2);

        // Reset ten cycles into a run: abort, no done, C cleared.
        cfg_accum = 1'b0; cfg_signed = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        repeat (9) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_done", int'(done), 0);
        check_ident("rst_clear", 0);

        // Fresh load with B[15] supplied in the start cycle itself.
        load_ident(1'b1);
        run(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 15, 15);
        check_ident("fresh", 1);

        for (int e = 0; e < 16; e++) begin
            wr(1'b0, e, sa[e]);
            wr(1'b1, e, sb[e]);
        end
        run(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        rd("signed", 0, 9, 9);
        rd("signed", 1, 10, 10);
        rd("signed", 4, -13, -13);
        rd("signed", 5, -14, -14);
        rd("signed", 10, 0, 0);

        fill(255, 255);
        run(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        for (int e = 0; e < 16; e += 5) rd("usat", e, 65535, 63492);

        fill(8'h80, 8'h80);
        run(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        for (int e = 0; e < 16; e += 5) rd("ssat_pos", e, 32767, 0);

        fill(8'h80, 8'h7F);
        run(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        for (int e = 0; e < 16; e += 5) rd("ssat_neg", e, -32768, 512);

        repeat (3) step();
        chk("done_pending", done_q.size(), 0);
        chk("rd_pending", rd_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
